key_event_router: RTL and testbench

//   Parametrised successor of the SW/KEY role manager. Routes NUM_KEYS debounced

---
 rtl/key_event_router.sv | 247 ++++++++++++++++++++++++
 tb/tb_key_event_router.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_router.sv
// ---------------------------------------------------------------------------
// key_event_router
//   Routes NUM_KEYS debounced keys to one of NUM_CH channels. The channel is
//   chosen by debounced mode switches. Emits single-cycle key events (press,
//   long-press, auto-repeat, release) and a per-channel level view of the keys.
//   Sits between the key debouncer and the terminal command/entry logic.
//
// Ports
//   clk        in   1                  system clock
//   rst_n      in   1                  asynchronous active-low reset
//   mode_sel   in   CH_W               debounced mode switches (channel select)
//   key        in   NUM_KEYS           debounced keys, 1 = pressed
//   evt_valid  out  1                  one-cycle event strobe
//   evt_chan   out  CH_W               channel of the last event
//   evt_key    out  KEY_W              key index of the last event
//   evt_kind   out  2                  00 press, 01 long, 10 repeat, 11 release
//   ch_level   out  NUM_CH*NUM_KEYS    slice c = synced keys if c is active, else 0
//   busy       out  1                  1 while the FSM is not idle
// ---------------------------------------------------------------------------
module key_event_router #(
   parameter int NUM_KEYS      = 4,
   parameter int NUM_CH        = 2,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   localparam int CH_W         = $clog2(NUM_CH),
   localparam int KEY_W        = $clog2(NUM_KEYS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CH_W-1:0]              mode_sel,
   input  logic [NUM_KEYS-1:0]          key,
   output logic                         evt_valid,
   output logic [CH_W-1:0]              evt_chan,
   output logic [KEY_W-1:0]             evt_key,
   output logic [1:0]                   evt_kind,
   output logic [NUM_CH*NUM_KEYS-1:0]   ch_level,
   output logic                         busy
);

   // One counter serves both the long-press and the repeat interval, so it is
   // sized for the larger of the two.
   localparam int CNT_TOP = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_TOP + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic             REP_EN    = (REPEAT_CYCLES != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_HOLD  = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      KIND_PRESS   = 2'b00,
      KIND_LONG    = 2'b01,
      KIND_REPEAT  = 2'b10,
      KIND_RELEASE = 2'b11
   } kind_t;

   // ------------------------------------------------------------------------
   // Two-flop synchronisers for keys and mode switches
   // ------------------------------------------------------------------------
   logic [NUM_KEYS-1:0] key_meta_q, ks_q;
   logic [CH_W-1:0]     ms_meta_q,  ms_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta_q <= '0;
         ks_q       <= '0;
         ms_meta_q  <= '0;
         ms_q       <= '0;
      end else begin
         key_meta_q <= key;
         ks_q       <= key_meta_q;
         ms_meta_q  <= mode_sel;
         ms_q       <= ms_meta_q;
      end
   end

   // Out-of-range switch codes (only possible when NUM_CH is not a power of
   // two) fall back to channel 0.
   logic [CH_W-1:0] ms_ch;

   generate
      if ((1 << CH_W) == NUM_CH) begin : g_ch_full
         assign ms_ch = ms_q;
      end else begin : g_ch_clamp
         assign ms_ch = (int'(ms_q) < NUM_CH) ? ms_q : '0;
      end
   endgenerate

   // Lowest-index pressed key wins when several rise together.
   logic [KEY_W-1:0] low_idx;

   always_comb begin
      low_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (ks_q[i]) begin
            low_idx = KEY_W'(i);
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [KEY_W-1:0] cur_key_q, cur_key_d;
   logic [CH_W-1:0]  act_ch_q, act_ch_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             fire;
   kind_t            kind_d;

   // Saturating increment: a very long hold with repeat disabled must not
   // wrap the counter.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      cur_key_d = cur_key_q;
      act_ch_d  = act_ch_q;
      cnt_d     = cnt_q;
      fire      = 1'b0;
      kind_d    = KIND_PRESS;

      case (state_q)
         ST_IDLE: begin
            if (|ks_q) begin
               cur_key_d = low_idx;
               act_ch_d  = ms_ch;
               cnt_d     = '0;
               fire      = 1'b1;
               kind_d    = KIND_PRESS;
               state_d   = ST_PRESS;
            end
         end

         ST_PRESS: begin
            // Release is tested first so it beats a coincident long-press.
            if (!ks_q[cur_key_q]) begin
               fire    = 1'b1;
               kind_d  = KIND_RELEASE;
               state_d = ST_WAIT;
            end else if (cnt_q == HOLD_LAST) begin
               fire    = 1'b1;
               kind_d  = KIND_LONG;
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_HOLD: begin
            if (!ks_q[cur_key_q]) begin
               fire    = 1'b1;
               kind_d  = KIND_RELEASE;
               state_d = ST_WAIT;
            end else if (REP_EN && (cnt_q == REP_LAST)) begin
               fire   = 1'b1;
               kind_d = KIND_REPEAT;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_WAIT: begin
            // Every key, including ones pressed while another was owned, must
            // be up before a new press is accepted.
            if (ks_q == '0) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // rst_n is expected to be deasserted synchronously to clk by the upstream
   // reset generator; assertion takes effect immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cur_key_q <= '0;
         act_ch_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         cur_key_q <= cur_key_d;
         act_ch_q  <= act_ch_d;
         cnt_q     <= cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------------
   logic                       evt_valid_q;
   logic [CH_W-1:0]            evt_chan_q;
   logic [KEY_W-1:0]           evt_key_q;
   logic [1:0]                 evt_kind_q;
   logic [NUM_CH*NUM_KEYS-1:0] ch_level_q, ch_level_d;

   // The level view follows the channel being loaded this cycle so that it
   // lines up with the press event.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_level
         assign ch_level_d[gi*NUM_KEYS +: NUM_KEYS] =
            (act_ch_d == CH_W'(gi)) ? ks_q : '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid_q <= 1'b0;
         evt_chan_q  <= '0;
         evt_key_q   <= '0;
         evt_kind_q  <= '0;
         ch_level_q  <= '0;
      end else begin
         evt_valid_q <= fire;
         // Event fields are sticky until the next event.
         if (fire) begin
            evt_chan_q <= act_ch_d;
            evt_key_q  <= cur_key_d;
            evt_kind_q <= kind_d;
         end
         ch_level_q <= ch_level_d;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_chan  = evt_chan_q;
   assign evt_key   = evt_key_q;
   assign evt_kind  = evt_kind_q;
   assign ch_level  = ch_level_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_event_router.sv
// ---------------------------------------------------------------------------
// tb_key_event_router
//   Directed bench for key_event_router with NUM_KEYS=4, NUM_CH=2,
//   HOLD_CYCLES=8. dut0 uses REPEAT_CYCLES=4, dut1 uses REPEAT_CYCLES=0; both
//   see the same inputs. Inputs change on the falling edge; events are logged
//   1 ns after each rising edge together with the rising-edge count.
// ---------------------------------------------------------------------------
module tb_key_event_router;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [0:0] mode_sel;
   logic [3:0] key;

   logic       evt_valid0, evt_valid1;
   logic [0:0] evt_chan0,  evt_chan1;
   logic [1:0] evt_key0,   evt_key1;
   logic [1:0] evt_kind0,  evt_kind1;
   logic [7:0] ch_level0,  ch_level1;
   logic       busy0,      busy1;

   key_event_router #(
      .NUM_KEYS      (4),
      .NUM_CH        (2),
      .HOLD_CYCLES   (8),
      .REPEAT_CYCLES (4)
   ) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_sel  (mode_sel),
      .key       (key),
      .evt_valid (evt_valid0),
      .evt_chan  (evt_chan0),
      .evt_key   (evt_key0),
      .evt_kind  (evt_kind0),
      .ch_level  (ch_level0),
      .busy      (busy0)
   );

   key_event_router #(
      .NUM_KEYS      (4),
      .NUM_CH        (2),
      .HOLD_CYCLES   (8),
      .REPEAT_CYCLES (0)
   ) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_sel  (mode_sel),
      .key       (key),
      .evt_valid (evt_valid1),
      .evt_chan  (evt_chan1),
      .evt_key   (evt_key1),
      .evt_kind  (evt_kind1),
      .ch_level  (ch_level1),
      .busy      (busy1)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Packed event record: {4'h0, cycle[15:0], chan[3:0], key[3:0], kind[3:0]}
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   function automatic logic [31:0] ev(input int c, input int ch, input int k, input int kind);
      return {4'h0, 16'(c), 4'(ch), 4'(k), 4'(kind)};
   endfunction

   always @(posedge clk) begin
      #1;
      if (evt_valid0) begin
         q0.push_back(ev(cyc, int'(evt_chan0), int'(evt_key0), int'(evt_kind0)));
         $display("dut0 event: cyc=%0d chan=%0d key=%0d kind=%0d", cyc, evt_chan0, evt_key0, evt_kind0);
      end
      if (evt_valid1) begin
         q1.push_back(ev(cyc, int'(evt_chan1), int'(evt_key1), int'(evt_kind1)));
         $display("dut1 event: cyc=%0d chan=%0d key=%0d kind=%0d", cyc, evt_chan1, evt_key1, evt_kind1);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   // Missing entries read as all-ones so they can never match an expectation.
   task automatic check_evt(input string tag, input int which, input int idx, input logic [31:0] exp);
      logic [31:0] obs;
      obs = 32'hFFFF_FFFF;
      if (which == 0 && idx < q0.size()) obs = q0[idx];
      if (which == 1 && idx < q1.size()) obs = q1[idx];
      check_eq(tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   int t;
   int t2;

   initial begin
      rst_n    = 1'b0;
      mode_sel = 1'b0;
      key      = 4'b0000;
      step(4);
      check_eq("reset_outputs_dut0", 32'({evt_valid0, evt_chan0, evt_key0, evt_kind0, ch_level0, busy0}), 32'd0);
      check_eq("reset_outputs_dut1", 32'({evt_valid1, evt_chan1, evt_key1, evt_kind1, ch_level1, busy1}), 32'd0);
      rst_n = 1'b1;
      step(2);

      // 1: short press of k2 on channel 0
      q0.delete();
      t = cyc;
      mode_sel = 1'b0;
      key = 4'b0100;
      step(3);
      key = 4'b0000;
      step(2);
      check_eq("t1_busy_during", 32'(busy0), 32'd1);
      step(5);
      check_eq("t1_busy_after", 32'(busy0), 32'd0);
      check_eq("t1_count", 32'(q0.size()), 32'd2);
      check_evt("t1_press", 0, 0, ev(t + 3, 0, 2, 0));
      check_evt("t1_release", 0, 1, ev(t + 6, 0, 2, 3));

      // 2: long hold of k0 on channel 1, release coincides with a repeat slot
      q0.delete();
      t = cyc;
      mode_sel = 1'b1;
      key = 4'b0001;
      step(10);
      check_eq("t2_level_held", 32'(ch_level0), 32'h10);
      step(10);
      key = 4'b0000;
      step(8);
      check_eq("t2_count", 32'(q0.size()), 32'd5);
      check_evt("t2_press", 0, 0, ev(t + 3, 1, 0, 0));
      check_evt("t2_long", 0, 1, ev(t + 11, 1, 0, 1));
      check_evt("t2_repeat1", 0, 2, ev(t + 15, 1, 0, 2));
      check_evt("t2_repeat2", 0, 3, ev(t + 19, 1, 0, 2));
      check_evt("t2_release", 0, 4, ev(t + 23, 1, 0, 3));
      check_eq("t2_sticky_fields", 32'({evt_valid0, evt_chan0, evt_key0, evt_kind0}), 32'({1'b0, 1'b1, 2'd0, 2'd3}));
      check_eq("t2_level_after", 32'(ch_level0), 32'h00);

      // 3: two keys rise together; only the lowest is owned
      q0.delete();
      t = cyc;
      mode_sel = 1'b0;
      key = 4'b0110;
      step(5);
      key = 4'b0100;
      step(10);
      check_eq("t3_busy_wait", 32'(busy0), 32'd1);
      check_eq("t3_count_wait", 32'(q0.size()), 32'd2);
      check_eq("t3_level_wait", 32'(ch_level0), 32'h04);
      key = 4'b0000;
      step(6);
      check_eq("t3_busy_after", 32'(busy0), 32'd0);
      check_evt("t3_press", 0, 0, ev(t + 3, 0, 1, 0));
      check_evt("t3_release", 0, 1, ev(t + 8, 0, 1, 3));

      // 4: mode change while in HOLD is deferred to the next press
      q0.delete();
      t = cyc;
      key = 4'b0001;
      step(13);
      mode_sel = 1'b1;
      step(3);
      key = 4'b0000;
      step(8);
      t2 = cyc;
      key = 4'b0010;
      step(4);
      key = 4'b0000;
      step(1);
      check_eq("t4_level_ch1", 32'(ch_level0), 32'h20);
      step(5);
      check_eq("t4_count", 32'(q0.size()), 32'd6);
      check_evt("t4_press", 0, 0, ev(t + 3, 0, 0, 0));
      check_evt("t4_long", 0, 1, ev(t + 11, 0, 0, 1));
      check_evt("t4_repeat", 0, 2, ev(t + 15, 0, 0, 2));
      check_evt("t4_release", 0, 3, ev(t + 19, 0, 0, 3));
      check_evt("t4_press_ch1", 0, 4, ev(t2 + 3, 1, 1, 0));
      check_evt("t4_release_ch1", 0, 5, ev(t2 + 7, 1, 1, 3));

      // 5: reset during HOLD, key still held afterwards
      q0.delete();
      t = cyc;
      key = 4'b1000;
      step(13);
      rst_n = 1'b0;
      #1;
      check_eq("t5_outputs_in_reset", 32'({evt_valid0, evt_chan0, evt_key0, evt_kind0, ch_level0, busy0}), 32'd0);
      step(2);
      rst_n = 1'b1;
      check_eq("t5_count_at_reset", 32'(q0.size()), 32'd2);
      step(5);
      key = 4'b0000;
      step(6);
      check_eq("t5_count", 32'(q0.size()), 32'd4);
      check_evt("t5_press", 0, 0, ev(t + 3, 1, 3, 0));
      check_evt("t5_long", 0, 1, ev(t + 11, 1, 3, 1));
      check_evt("t5_press_after_reset", 0, 2, ev(t + 18, 1, 3, 0));
      check_evt("t5_release", 0, 3, ev(t + 23, 1, 3, 3));

      // 6: 30-cycle hold; dut1 has repeat disabled
      step(2);
      q0.delete();
      q1.delete();
      t = cyc;
      mode_sel = 1'b1;
      key = 4'b0100;
      step(30);
      key = 4'b0000;
      step(8);
      check_eq("t6_norep_count", 32'(q1.size()), 32'd3);
      check_evt("t6_norep_press", 1, 0, ev(t + 3, 1, 2, 0));
      check_evt("t6_norep_long", 1, 1, ev(t + 11, 1, 2, 1));
      check_evt("t6_norep_release", 1, 2, ev(t + 33, 1, 2, 3));
      check_eq("t6_rep_count", 32'(q0.size()), 32'd8);
      check_evt("t6_rep_first", 0, 2, ev(t + 15, 1, 2, 2));
      check_evt("t6_rep_release", 0, 7, ev(t + 33, 1, 2, 3));
      check_eq("t6_busy_after", 32'({busy0, busy1}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
